// File: rtl/dbg_obi_master_arbiter.sv
// -----------------------------------------------------------------------------
// dbg_obi_master_arbiter
//
// Shares the debug module's single OBI system-bus master port between NrReq
// requesters, for example the SBA path and a boot/test loader. Arbitration is
// round-robin. Only one transaction is in flight at a time. The selected
// requester owns the port from request through grant to rvalid, and the
// response is routed back to that owner only.
//
// Optional feature: define DBG_OBI_ARB_TIMEOUT_EN to add an rvalid watchdog.
// When the watchdog expires after TimeoutCycles cycles in WAIT_RVALID, the
// owner receives an error response with rdata 32'hBADCAB1E, replicated or
// truncated to DataWidth.
//
// Ports
//   clk_i, rst_i         clock and synchronous active-high reset
//   req_i/we_i           per-requester OBI request and write enable
//   be_i/addr_i/wdata_i  per-requester fields, requester k at slice k
//   gnt_o/rvalid_o/err_o per-requester grant, response valid and error
//   rdata_o              shared response data, qualified by rvalid_o
//   busy_o               high while a transaction is pending
//   master_*_o           downstream OBI request channel
//   master_gnt_i, master_rvalid_i, master_rdata_i  downstream handshake/response
// -----------------------------------------------------------------------------
module dbg_obi_master_arbiter #(
   parameter int unsigned NrReq         = 2,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NrReq-1:0]             req_i,
   input  logic [NrReq-1:0]             we_i,
   input  logic [NrReq*DataWidth/8-1:0] be_i,
   input  logic [NrReq*AddrWidth-1:0]   addr_i,
   input  logic [NrReq*DataWidth-1:0]   wdata_i,
   output logic [NrReq-1:0]             gnt_o,
   output logic [NrReq-1:0]             rvalid_o,
   output logic [DataWidth-1:0]         rdata_o,
   output logic [NrReq-1:0]             err_o,
   output logic                         busy_o,
   output logic                         master_req_o,
   output logic                         master_we_o,
   output logic [DataWidth/8-1:0]       master_be_o,
   output logic [AddrWidth-1:0]         master_addr_o,
   output logic [DataWidth-1:0]         master_wdata_o,
   input  logic                         master_gnt_i,
   input  logic                         master_rvalid_i,
   input  logic [DataWidth-1:0]         master_rdata_i
);

   localparam int unsigned IdxWidth = $clog2(NrReq);
   localparam int unsigned BeWidth  = DataWidth / 8;

   typedef enum logic [1:0] {
      StIdle,
      StWaitGnt,
      StWaitRvalid
   } state_e;

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] rrPtr_q, rrPtr_d;
   logic [IdxWidth-1:0] owner_q, owner_d;
   logic [IdxWidth-1:0] winner;
   logic [IdxWidth-1:0] selIdx;
   logic                anyReq;
   logic                masterReq;
   int unsigned         cand;

   // Round-robin successor of a requester index, wrapping at NrReq-1 so that
   // non-power-of-two requester counts also work.
   function automatic logic [IdxWidth-1:0] incIdx(input logic [IdxWidth-1:0] idx);
      if (idx == IdxWidth'(NrReq - 1)) begin
         return '0;
      end
      return idx + IdxWidth'(1);
   endfunction

`ifdef DBG_OBI_ARB_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;
   localparam logic [31:0] TimeoutPattern = 32'hBADCAB1E;

   // The error data word is the 32-bit pattern repeated across the data bus.
   // For buses narrower than 32 bits, the pattern is simply cut down.
   function automatic logic [DataWidth-1:0] timeoutWord();
      logic [DataWidth-1:0] v;
      v = '0;
      for (int unsigned b = 0; b < DataWidth; b++) begin
         v[b] = TimeoutPattern[b % 32];
      end
      return v;
   endfunction

   localparam logic [DataWidth-1:0] TimeoutData = timeoutWord();

   logic [CntWidth-1:0] timeoutCnt_q, timeoutCnt_d;

   // The watchdog sits at zero outside WAIT_RVALID, so every entry into
   // WAIT_RVALID starts counting from zero. It then counts once per cycle
   // spent waiting for the response.
   always_comb begin
      timeoutCnt_d = '0;
      if (state_q == StWaitRvalid) begin
         timeoutCnt_d = timeoutCnt_q + CntWidth'(1);
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timeoutCnt_q <= '0;
      end else begin
         timeoutCnt_q <= timeoutCnt_d;
      end
   end
`else
   // TimeoutCycles only sizes the optional watchdog. This empty reference
   // keeps the parameter part of the interface in every build.
   if (TimeoutCycles == 0) begin : gNoWatchdog
   end
`endif

   // Winner search: scan the offsets from the far end back towards rrPtr_q.
   // The last requester found is then the one closest to the pointer in
   // round-robin order.
   always_comb begin
      winner = rrPtr_q;
      cand   = 0;
      anyReq = |req_i;
      for (int unsigned off = NrReq; off > 0; off--) begin
         cand = 32'(rrPtr_q) + off - 1;
         if (cand >= NrReq) begin
            cand = cand - NrReq;
         end
         if (req_i[IdxWidth'(cand)]) begin
            winner = IdxWidth'(cand);
         end
      end
   end

   // Next-state and handshake logic.
   // In IDLE, the request fields come straight from the winner, so a grant is
   // possible in the first cycle.
   // After that, the registered owner is locked in until its response arrives.
   // If the owner withdraws before its grant, the attempt is abandoned without
   // moving the round-robin pointer.
   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      owner_d   = owner_q;
      selIdx    = owner_q;
      masterReq = 1'b0;
      gnt_o     = '0;
      rvalid_o  = '0;
      err_o     = '0;
      rdata_o   = '0;
      unique case (state_q)
         StIdle: begin
            if (anyReq) begin
               masterReq = 1'b1;
               selIdx    = winner;
               owner_d   = winner;
               if (master_gnt_i) begin
                  gnt_o[winner] = 1'b1;
                  rrPtr_d       = incIdx(winner);
                  state_d       = StWaitRvalid;
               end else begin
                  state_d = StWaitGnt;
               end
            end
         end
         StWaitGnt: begin
            if (!req_i[owner_q]) begin
               state_d = StIdle;
            end else begin
               masterReq = 1'b1;
               if (master_gnt_i) begin
                  gnt_o[owner_q] = 1'b1;
                  rrPtr_d        = incIdx(owner_q);
                  state_d        = StWaitRvalid;
               end
            end
         end
         StWaitRvalid: begin
            if (master_rvalid_i) begin
               rvalid_o[owner_q] = 1'b1;
               rdata_o           = master_rdata_i;
               state_d           = StIdle;
            end
`ifdef DBG_OBI_ARB_TIMEOUT_EN
            else if (timeoutCnt_q == CntWidth'(TimeoutCycles - 1)) begin
               rvalid_o[owner_q] = 1'b1;
               err_o[owner_q]    = 1'b1;
               rdata_o           = TimeoutData;
               state_d           = StIdle;
            end
`endif
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Downstream request channel: mux the selected requester's slices.
   // The fields are held at zero whenever no request is presented.
   always_comb begin
      master_req_o   = masterReq;
      master_we_o    = 1'b0;
      master_be_o    = '0;
      master_addr_o  = '0;
      master_wdata_o = '0;
      if (masterReq) begin
         master_we_o    = we_i[selIdx];
         master_be_o    = be_i[selIdx*BeWidth +: BeWidth];
         master_addr_o  = addr_i[selIdx*AddrWidth +: AddrWidth];
         master_wdata_o = wdata_i[selIdx*DataWidth +: DataWidth];
      end
   end

   assign busy_o = (state_q != StIdle);

   // State, round-robin pointer and owner registers. A reset in WAIT_RVALID
   // drops the outstanding transaction. Because IDLE ignores master_rvalid_i,
   // a late response is dropped as well.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         rrPtr_q <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         rrPtr_q <= rrPtr_d;
         owner_q <= owner_d;
      end
   end

endmodule

// File: tb/tb_dbg_obi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbg_obi_master_arbiter
//
// Directed self-checking bench for dbg_obi_master_arbiter with two requesters
// and 32-bit address/data. Each scenario task drives its own vectors and
// compares against hand-computed values. The bench drives inputs 1 ns after
// the rising edge and samples outputs 2 ns later.
// -----------------------------------------------------------------------------
module tb_dbg_obi_master_arbiter;

   localparam int unsigned NrReq = 2;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [NrReq-1:0]    req_i, we_i;
   logic [NrReq*4-1:0]  be_i;
   logic [NrReq*AW-1:0] addr_i;
   logic [NrReq*DW-1:0] wdata_i;
   logic [NrReq-1:0]    gnt_o, rvalid_o, err_o;
   logic [DW-1:0]       rdata_o;
   logic                busy_o;
   logic                master_req_o, master_we_o;
   logic [3:0]          master_be_o;
   logic [AW-1:0]       master_addr_o;
   logic [DW-1:0]       master_wdata_o;
   logic                master_gnt_i, master_rvalid_i;
   logic [DW-1:0]       master_rdata_i;

   int compared   = 0;
   int mismatched = 0;

   dbg_obi_master_arbiter #(
      .NrReq        (NrReq),
      .AddrWidth    (AW),
      .DataWidth    (DW),
      .TimeoutCycles(16)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .we_i           (we_i),
      .be_i           (be_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .gnt_o          (gnt_o),
      .rvalid_o       (rvalid_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .busy_o         (busy_o),
      .master_req_o   (master_req_o),
      .master_we_o    (master_we_o),
      .master_be_o    (master_be_o),
      .master_addr_o  (master_addr_o),
      .master_wdata_o (master_wdata_o),
      .master_gnt_i   (master_gnt_i),
      .master_rvalid_i(master_rvalid_i),
      .master_rdata_i (master_rdata_i)
   );

   // 100 MHz clock
   always #5 clk_i = ~clk_i;

   // Advance to 1 ns after the next rising edge, where the bench drives inputs.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Return every requester and downstream input to a quiet, idle value.
   // Requester 0 and requester 1 get distinct field values so the mux
   // selection is visible.
   task automatic applyStimulus();
      req_i           = '0;
      we_i            = '0;
      be_i            = {4'b1100, 4'b1111};
      addr_i          = {32'h2000_0000, 32'h1000_0000};
      wdata_i         = {32'h2222_2222, 32'h1111_1111};
      master_gnt_i    = 1'b0;
      master_rvalid_i = 1'b0;
      master_rdata_i  = '0;
   endtask

   task automatic test_reset();
      applyStimulus();
      rst_i = 1'b1;
      tick();
      tick();
      #2;
      compared++;
      if (busy_o !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_busy got=%b want=0", busy_o);
      end
      compared++;
      if ({gnt_o, rvalid_o, err_o, master_req_o} !== 7'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_outs got=%b want=0", {gnt_o, rvalid_o, err_o, master_req_o});
      end
      compared++;
      if ({master_we_o, master_be_o, master_addr_o, master_wdata_o, rdata_o} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_fields got addr=%h wdata=%h rdata=%h want 0",
                  master_addr_o, master_wdata_o, rdata_o);
      end
      tick();
      rst_i = 1'b0;
   endtask

   // A single read by requester 0. The grant comes in cycle 0 and the
   // response in cycle 2. The round-robin pointer moves to 1.
   task automatic test_single_read();
      tick();
      req_i        = 2'b01;
      addr_i[31:0] = 32'h1A11_0000;
      master_gnt_i = 1'b1;
      #2;
      compared++;
      if (gnt_o !== 2'b01 || master_req_o !== 1'b1 || busy_o !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read_c0 got gnt=%b req=%b busy=%b want 01/1/0", gnt_o, master_req_o, busy_o);
      end
      compared++;
      if (master_addr_o !== 32'h1A11_0000 || master_we_o !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read_addr got=%h we=%b want=1a110000 we=0", master_addr_o, master_we_o);
      end
      tick();
      applyStimulus();
      #2;
      compared++;
      if (busy_o !== 1'b1 || rvalid_o !== 2'b00 || master_req_o !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read_c1 got busy=%b rvalid=%b req=%b want 1/00/0", busy_o, rvalid_o, master_req_o);
      end
      tick();
      master_rvalid_i = 1'b1;
      master_rdata_i  = 32'h1234_5678;
      #2;
      compared++;
      if (rvalid_o !== 2'b01 || rdata_o !== 32'h1234_5678 || busy_o !== 1'b1 || err_o !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL read_c2 got rvalid=%b rdata=%h busy=%b err=%b want 01/12345678/1/00",
                  rvalid_o, rdata_o, busy_o, err_o);
      end
      tick();
      applyStimulus();
      #2;
      compared++;
      if (busy_o !== 1'b0 || rvalid_o !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL read_c3 got busy=%b rvalid=%b want 0/00", busy_o, rvalid_o);
      end
   endtask

   // Requester 1 writes while requester 0 has different fields present.
   // The write fields must come from slice 1 only. The pointer moves to 0.
   task automatic test_write();
      tick();
      req_i          = 2'b10;
      we_i           = 2'b10;
      be_i[7:4]      = 4'b0011;
      wdata_i[63:32] = 32'hCAFE_F00D;
      addr_i[63:32]  = 32'h2000_0040;
      master_gnt_i   = 1'b1;
      #2;
      compared++;
      if (gnt_o !== 2'b10 || master_we_o !== 1'b1 || master_be_o !== 4'b0011) begin
         mismatched++;
         $display("[TB] FAIL write_ctl got gnt=%b we=%b be=%b want 10/1/0011", gnt_o, master_we_o, master_be_o);
      end
      compared++;
      if (master_wdata_o !== 32'hCAFE_F00D || master_addr_o !== 32'h2000_0040) begin
         mismatched++;
         $display("[TB] FAIL write_data got wdata=%h addr=%h want cafef00d/20000040", master_wdata_o, master_addr_o);
      end
      tick();
      applyStimulus();
      master_rvalid_i = 1'b1;
      master_rdata_i  = 32'h0000_00AA;
      #2;
      compared++;
      if (rvalid_o !== 2'b10 || rdata_o !== 32'h0000_00AA) begin
         mismatched++;
         $display("[TB] FAIL write_rvalid got rvalid=%b rdata=%h want 10/000000aa", rvalid_o, rdata_o);
      end
      tick();
      applyStimulus();
   endtask

   // Both requesters hold req continuously, and the downstream grants at once.
   // Even cycles are grants in IDLE, alternating 01,10,01,10. Odd cycles
   // deliver the response, and no new grant appears in those cycles.
   task automatic test_contention();
      logic [1:0] expGnt [4];
      expGnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int c = 0; c < 8; c++) begin
         tick();
         req_i           = 2'b11;
         master_gnt_i    = 1'b1;
         master_rvalid_i = (c % 2 == 1);
         master_rdata_i  = 32'(c);
         #2;
         compared++;
         if (c % 2 == 0) begin
            if (gnt_o !== expGnt[c/2] || rvalid_o !== 2'b00) begin
               mismatched++;
               $display("[TB] FAIL contention_gnt c=%0d got gnt=%b rvalid=%b want %b/00",
                        c, gnt_o, rvalid_o, expGnt[c/2]);
            end
         end else begin
            if (gnt_o !== 2'b00 || rvalid_o !== expGnt[c/2] || rdata_o !== 32'(c)) begin
               mismatched++;
               $display("[TB] FAIL contention_rsp c=%0d got gnt=%b rvalid=%b rdata=%h want 00/%b/%h",
                        c, gnt_o, rvalid_o, rdata_o, expGnt[c/2], 32'(c));
            end
         end
      end
      tick();
      applyStimulus();
   endtask

   // Requester 1 waits 3 cycles for its grant. Requester 0 joins in cycle 1
   // but must not steal the port. After the grant, requester 0 is served next.
   task automatic test_grant_stall();
      for (int c = 0; c < 4; c++) begin
         tick();
         req_i        = (c == 0) ? 2'b10 : 2'b11;
         master_gnt_i = (c == 3);
         #2;
         compared++;
         if (master_addr_o !== 32'h2000_0000 || master_req_o !== 1'b1 ||
             gnt_o !== ((c == 3) ? 2'b10 : 2'b00)) begin
            mismatched++;
            $display("[TB] FAIL stall c=%0d got addr=%h req=%b gnt=%b want 20000000/1/%b",
                     c, master_addr_o, master_req_o, gnt_o, (c == 3) ? 2'b10 : 2'b00);
         end
      end
      tick();
      req_i           = 2'b01;
      master_gnt_i    = 1'b0;
      master_rvalid_i = 1'b1;
      #2;
      compared++;
      if (rvalid_o !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL stall_rvalid got=%b want=10", rvalid_o);
      end
      tick();
      master_rvalid_i = 1'b0;
      master_gnt_i    = 1'b1;
      #2;
      compared++;
      if (gnt_o !== 2'b01 || master_addr_o !== 32'h1000_0000) begin
         mismatched++;
         $display("[TB] FAIL stall_next got gnt=%b addr=%h want 01/10000000", gnt_o, master_addr_o);
      end
      tick();
      applyStimulus();
      master_rvalid_i = 1'b1;
      tick();
      applyStimulus();
   endtask

   // Requester 0 withdraws its request while waiting for a grant. The
   // downstream request must drop and the arbiter returns to IDLE. The
   // pointer stays at 1, so contention then favours requester 1.
   task automatic test_withdraw();
      tick();
      req_i = 2'b01;
      #2;
      compared++;
      if (master_req_o !== 1'b1 || gnt_o !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL withdraw_c0 got req=%b gnt=%b want 1/00", master_req_o, gnt_o);
      end
      tick();
      req_i        = 2'b00;
      master_gnt_i = 1'b1;
      #2;
      compared++;
      if (master_req_o !== 1'b0 || gnt_o !== 2'b00 || busy_o !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL withdraw_drop got req=%b gnt=%b busy=%b want 0/00/1", master_req_o, gnt_o, busy_o);
      end
      tick();
      req_i = 2'b11;
      #2;
      compared++;
      if (busy_o !== 1'b0 || gnt_o !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL withdraw_ptr got busy=%b gnt=%b want 0/10", busy_o, gnt_o);
      end
      tick();
      applyStimulus();
      master_rvalid_i = 1'b1;
      tick();
      applyStimulus();
   endtask

   // Reset is applied while the arbiter waits for rvalid. The late response
   // must be dropped, and the pointer (1 before reset) returns to 0.
   task automatic test_reset_mid();
      tick();
      req_i        = 2'b01;
      master_gnt_i = 1'b1;
      #2;
      compared++;
      if (gnt_o !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL rstmid_gnt got=%b want=01", gnt_o);
      end
      tick();
      applyStimulus();
      rst_i = 1'b1;
      tick();
      rst_i           = 1'b0;
      master_rvalid_i = 1'b1;
      master_rdata_i  = 32'hDEAD_BEEF;
      #2;
      compared++;
      if (rvalid_o !== 2'b00 || busy_o !== 1'b0 || rdata_o !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL rstmid_drop got rvalid=%b busy=%b rdata=%h want 00/0/0", rvalid_o, busy_o, rdata_o);
      end
      tick();
      applyStimulus();
      req_i        = 2'b11;
      master_gnt_i = 1'b1;
      #2;
      compared++;
      if (gnt_o !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL rstmid_next got=%b want=01", gnt_o);
      end
      tick();
      applyStimulus();
      master_rvalid_i = 1'b1;
      tick();
      applyStimulus();
   endtask

`ifdef DBG_OBI_ARB_TIMEOUT_EN
   // With TimeoutCycles=16 and no response, the 16th WAIT_RVALID cycle
   // delivers an error response to requester 1. The arbiter is IDLE
   // afterwards.
   task automatic test_timeout();
      tick();
      req_i        = 2'b10;
      master_gnt_i = 1'b1;
      tick();
      applyStimulus();
      for (int c = 1; c <= 16; c++) begin
         #2;
         compared++;
         if (c < 16) begin
            if (rvalid_o !== 2'b00 || err_o !== 2'b00) begin
               mismatched++;
               $display("[TB] FAIL timeout_early c=%0d got rvalid=%b err=%b want 00/00", c, rvalid_o, err_o);
            end
            tick();
         end else begin
            if (rvalid_o !== 2'b10 || err_o !== 2'b10 || rdata_o !== 32'hBADC_AB1E) begin
               mismatched++;
               $display("[TB] FAIL timeout_fire got rvalid=%b err=%b rdata=%h want 10/10/badcab1e",
                        rvalid_o, err_o, rdata_o);
            end
         end
      end
      tick();
      #2;
      compared++;
      if (busy_o !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL timeout_idle got busy=%b want 0", busy_o);
      end
   endtask
`endif

   // Scenario sequence
   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_contention();
      test_grant_stall();
      test_withdraw();
      test_reset_mid();
`ifdef DBG_OBI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
